// File: rtl/corelet_seq_pkg.sv
// corelet_seq_pkg: instruction field positions, idle word and sequencer states
package corelet_seq_pkg;
  typedef logic [15:0] cnt_t;
  localparam int B_BYPASS   = 34;
  localparam int B_ACC      = 33;
  localparam int B_CEN_PMEM = 32;
  localparam int B_WEN_PMEM = 31;
  localparam int B_A_PMEM   = 20;
  localparam int B_CEN_XMEM = 19;
  localparam int B_WEN_XMEM = 18;
  localparam int B_A_XMEM   = 7;
  localparam int B_OFIFO_RD = 6;
  localparam int B_IFIFO_WR = 5;
  localparam int B_IFIFO_RD = 4;
  localparam int B_L0_RD    = 3;
  localparam int B_L0_WR    = 2;
  localparam int B_EXECUTE  = 1;
  localparam int B_LOAD     = 0;
  localparam logic [34:0] IDLE_WORD = 35'h1_800C_0000;
  typedef enum logic [2:0] {IDLE, WLD, WLOAD, WGAP, XFEED, DRAIN, ACC, DONE} state_e;
endpackage

// File: rtl/corelet_seq_addr.sv
// corelet_seq_addr: xmem/pmem address generation, 11-bit wrap-around arithmetic
module corelet_seq_addr import corelet_seq_pkg::*; #(
  parameter int row = 8,
  parameter int N_X = 36,
  parameter logic [10:0] W_BASE = 11'd0,
  parameter logic [10:0] X_BASE = 11'd128,
  parameter logic [10:0] P_BASE = 11'd0
) (
  input  logic [2:0]  state,
  input  logic [10:0] c,
  input  logic [10:0] kij,
  input  logic [10:0] n,
  input  logic [10:0] o,
  output logic [10:0] a_xmem,
  output logic [10:0] a_pmem
);
  localparam logic [10:0] R  = 11'(row);
  localparam logic [10:0] NX = 11'(N_X);
  assign a_xmem = state == WLD ? W_BASE + kij * R + c : X_BASE + c;
  // outside DRAIN the phase counter c is the kernel position of the ACC read
  assign a_pmem = state == DRAIN ? P_BASE + kij * NX + n : P_BASE + c * NX + o;
endmodule

// File: rtl/corelet_seq.sv
// corelet_seq: corelet instruction sequencer; define CORELET_SEQ_ACC_EN to add the accumulate/ReLU pass
module corelet_seq import corelet_seq_pkg::*; #(
  parameter int row = 8,
  parameter int col = 8,
  parameter int KIJ = 9,
  parameter int N_X = 36,
  parameter logic [10:0] W_BASE = 11'd0,
  parameter logic [10:0] X_BASE = 11'd128,
  parameter logic [10:0] P_BASE = 11'd0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        ofifo_valid,
  output logic [34:0] inst,
  output logic        busy,
  output logic        done
);
  localparam cnt_t R   = cnt_t'(row);
  localparam cnt_t R1  = cnt_t'(row - 1);
  localparam cnt_t RC1 = cnt_t'(row + col - 1);
  localparam cnt_t NX  = cnt_t'(N_X);
  localparam cnt_t NX1 = cnt_t'(N_X - 1);
  localparam cnt_t NX2 = cnt_t'(N_X + 1);
  localparam cnt_t K   = cnt_t'(KIJ);
  localparam cnt_t K1  = cnt_t'(KIJ - 1);
`ifdef CORELET_SEQ_ACC_EN
  localparam state_e LAST = ACC;
`else
  localparam state_e LAST = DONE;
`endif
  state_e state_q, state_d;
  cnt_t c_q, c_d, kij_q, kij_d, n_q, n_d, o_q, o_d;
  logic [34:0] inst_q, inst_d;
  logic busy_q, busy_d, done_q, done_d, rd;
  logic [10:0] a_xmem, a_pmem;
  corelet_seq_addr #(
    .row(row), .N_X(N_X), .W_BASE(W_BASE), .X_BASE(X_BASE), .P_BASE(P_BASE)
  ) u_addr (
    .state(state_q), .c(c_q[10:0]), .kij(kij_q[10:0]), .n(n_q[10:0]), .o(o_q[10:0]),
    .a_xmem(a_xmem), .a_pmem(a_pmem)
  );
  always_comb begin
    state_d = state_q;
    c_d = c_q + cnt_t'(1);
    kij_d = kij_q;
    n_d = n_q;
    o_d = o_q;
    inst_d = IDLE_WORD;
    busy_d = 1'b1;
    done_d = 1'b0;
    rd = 1'b0;
    case (state_q)
      IDLE: begin
        busy_d = start;
        c_d = '0;
        if (start) begin
          state_d = WLD;
          kij_d = '0;
        end
      end
      WLD: begin
        rd = c_q < R;
        inst_d[B_CEN_XMEM] = !rd;
        inst_d[B_A_XMEM +: 11] = rd ? a_xmem : '0;
        inst_d[B_L0_WR] = c_q != '0;
        if (c_q == R) begin
          state_d = WLOAD;
          c_d = '0;
        end
      end
      WLOAD: begin
        inst_d[B_L0_RD] = 1'b1;
        inst_d[B_LOAD] = 1'b1;
        if (c_q == R1) begin
          state_d = WGAP;
          c_d = '0;
        end
      end
      WGAP: if (c_q == RC1) begin
        state_d = XFEED;
        c_d = '0;
      end
      XFEED: begin
        rd = c_q < NX;
        inst_d[B_CEN_XMEM] = !rd;
        inst_d[B_A_XMEM +: 11] = rd ? a_xmem : '0;
        inst_d[B_L0_WR] = c_q != '0 && c_q != NX2;
        inst_d[B_L0_RD] = c_q >= cnt_t'(2);
        inst_d[B_EXECUTE] = c_q >= cnt_t'(2);
        if (c_q == NX2) begin
          state_d = DRAIN;
          c_d = '0;
          n_d = '0;
        end
      end
      DRAIN: begin
        c_d = '0;
        if (ofifo_valid) begin
          inst_d[B_OFIFO_RD] = 1'b1;
          inst_d[B_CEN_PMEM] = 1'b0;
          inst_d[B_WEN_PMEM] = 1'b0;
          inst_d[B_A_PMEM +: 11] = a_pmem;
          n_d = n_q + cnt_t'(1);
          if (n_q == NX1) begin
            n_d = '0;
            o_d = '0;
            state_d = kij_q != K1 ? WLD : LAST;
            kij_d = kij_q != K1 ? kij_q + cnt_t'(1) : kij_q;
          end
        end
      end
`ifdef CORELET_SEQ_ACC_EN
      ACC: begin
        rd = c_q < K;
        inst_d[B_CEN_PMEM] = !rd;
        inst_d[B_A_PMEM +: 11] = rd ? a_pmem : '0;
        inst_d[B_ACC] = rd && c_q != '0;
        if (c_q == K) begin
          c_d = '0;
          o_d = o_q + cnt_t'(1);
          if (o_q == NX1) state_d = DONE;
        end
      end
`endif
      DONE: begin
        busy_d = 1'b0;
        done_d = 1'b1;
        c_d = '0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      c_q <= '0;
      kij_q <= '0;
      n_q <= '0;
      o_q <= '0;
      inst_q <= IDLE_WORD;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      state_q <= state_d;
      c_q <= c_d;
      kij_q <= kij_d;
      n_q <= n_d;
      o_q <= o_d;
      inst_q <= inst_d;
      busy_q <= busy_d;
      done_q <= done_d;
    end
  end
  assign inst = inst_q;
  assign busy = busy_q;
  assign done = done_q;
endmodule

// File: tb/tb_corelet_seq.sv
// tb_corelet_seq: randomized bench against a phase-table model of the tile instruction stream
module tb_corelet_seq;
  localparam int ROW = 8, COL = 8, KIJ = 9, NX = 36, WB = 0, XB = 128, PB = 0;
  localparam logic [34:0] IW = 35'h1_800C_0000;
  logic clk = 0, reset = 0, start = 0, ofifo_valid = 0;
  logic [34:0] inst;
  logic busy, done;
  int n_chk = 0, n_pass = 0;
  bit cmp_on = 0;
  logic [34:0] e_inst = IW;
  logic e_busy = 0, e_done = 0;
  logic [36:0] pend[$];
  int m_kij = 0, m_n = 0;
  bit m_act = 0, m_drain = 0;
  logic [34:0] trace[$];

  corelet_seq #(.row(ROW), .col(COL), .KIJ(KIJ), .N_X(NX),
    .W_BASE(11'(WB)), .X_BASE(11'(XB)), .P_BASE(11'(PB))) dut (
    .clk(clk), .reset(reset), .start(start), .ofifo_valid(ofifo_valid),
    .inst(inst), .busy(busy), .done(done));

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [34:0] act, input logic [34:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  function automatic logic [34:0] xrd(int a);
    logic [34:0] w = IW;
    w[19] = 1'b0;
    w[17:7] = 11'(a);
    return w;
  endfunction

  function automatic logic [34:0] pwr(int a);
    logic [34:0] w = IW;
    w[32] = 1'b0;
    w[31] = 1'b0;
    w[30:20] = 11'(a);
    w[6] = 1'b1;
    return w;
  endfunction

  // one kij of weight load, gap and activation feed, then a marker that opens the drain
  task automatic push_tile(int k);
    logic [34:0] w;
    for (int c = 0; c <= ROW; c++) begin
      w = c < ROW ? xrd(WB + k * ROW + c) : IW;
      w[2] = c > 0;
      pend.push_back({2'b00, w});
    end
    for (int c = 0; c < ROW; c++) begin
      w = IW; w[3] = 1'b1; w[0] = 1'b1;
      pend.push_back({2'b00, w});
    end
    for (int c = 0; c < ROW + COL; c++) pend.push_back({2'b00, IW});
    for (int c = 0; c < NX + 2; c++) begin
      w = c < NX ? xrd(XB + c) : IW;
      w[2] = c >= 1 && c <= NX;
      w[3] = c >= 2;
      w[1] = c >= 2;
      pend.push_back({2'b00, w});
    end
    pend.push_back({2'b01, IW});
  endtask

`ifdef CORELET_SEQ_ACC_EN
  task automatic push_acc();
    logic [34:0] w;
    for (int o = 0; o < NX; o++)
      for (int k = 0; k <= KIJ; k++) begin
        w = IW;
        if (k < KIJ) begin w[32] = 1'b0; w[30:20] = 11'(PB + k * NX + o); end
        w[33] = k >= 1 && k < KIJ;
        pend.push_back({2'b00, w});
      end
  endtask
`endif

  initial forever begin
    logic [36:0] it;
    @(posedge clk or negedge reset);
    if (!reset) begin
      pend.delete(); m_act = 0; m_drain = 0; e_inst = IW; e_busy = 0; e_done = 0;
    end else begin
      e_done = 0;
      if (!m_act) begin
        e_inst = IW;
        e_busy = start;
        if (start) begin m_act = 1; m_kij = 0; m_n = 0; push_tile(0); end
      end else begin
        if (pend.size() > 0 && pend[0][36:35] == 2'b01) begin void'(pend.pop_front()); m_drain = 1; end
        if (m_drain) begin
          e_inst = IW;
          if (ofifo_valid) begin
            e_inst = pwr(PB + m_kij * NX + m_n);
            m_n++;
            if (m_n == NX) begin
              m_drain = 0; m_n = 0;
              if (m_kij < KIJ - 1) begin m_kij++; push_tile(m_kij); end
              else begin
`ifdef CORELET_SEQ_ACC_EN
                push_acc();
`endif
                pend.push_back({2'b10, IW});
              end
            end
          end
        end else begin
          it = pend.pop_front();
          e_inst = it[34:0];
          if (it[36:35] == 2'b10) begin e_done = 1; e_busy = 0; m_act = 0; end
        end
      end
    end
  end

  initial forever begin
    @(negedge clk);
    if (cmp_on) begin
      chk("inst", inst, e_inst);
      chk("busy", 35'(busy), 35'(e_busy));
      chk("done", 35'(done), 35'(e_done));
    end
  end

  task automatic run_tile(input bit toggle, input bit spam);
    int ndone = 0;
    bit got = 0;
    trace.delete();
    @(negedge clk); start = 1;
    @(negedge clk); start = 0;
    for (int cyc = 0; cyc < 8000 && !got; cyc++) begin
      trace.push_back(inst);
      if (done) begin got = 1; ndone++; end
      ofifo_valid = toggle ? ~cyc[0] : ($urandom_range(0, 3) != 0);
      start = spam && busy && !done && ($urandom_range(0, 9) == 0);
      @(negedge clk);
    end
    chk("tile_done_seen", 35'(got), 35'(1));
    for (int i = 0; i < 6; i++) begin
      if (done) ndone++;
      @(negedge clk);
    end
    chk("done_pulses", 35'(ndone), 35'(1));
  endtask

  task automatic analyze(input bit toggle);
    int wi[$], wa[$];
    int l0 = 0, ofr = 0;
    logic [1:0] hi = '0;
    for (int i = 0; i < trace.size(); i++) begin
      hi |= trace[i][34:33];
      if (trace[i][6]) ofr++;
      if (!trace[i][32] && !trace[i][31]) begin wi.push_back(i); wa.push_back(int'(trace[i][30:20])); end
      if (i < 18 && trace[i][2]) l0++;
    end
    chk("first_idle", trace[0], IW);
    for (int i = 0; i < ROW; i++)
      chk("wld_rd", 35'({trace[1 + i][19], trace[1 + i][17:7]}), 35'({1'b0, 11'(WB + i)}));
    chk("l0_wr_count", 35'(l0), 35'(ROW));
    chk("l0_wr_lag", 35'({trace[1][2], trace[ROW + 1][2]}), 35'(2'b01));
    chk("wr_count", 35'(wa.size()), 35'(KIJ * NX));
    chk("ofifo_rd_count", 35'(ofr), 35'(KIJ * NX));
    if (wa.size() == KIJ * NX) begin
      chk("kij2_first_wr", 35'(wa[2 * NX]), 35'(72));
      chk("kij2_last_wr", 35'(wa[3 * NX - 1]), 35'(107));
      if (toggle) chk("toggle_gap", 35'(wi[2 * NX + 1] - wi[2 * NX]), 35'(2));
`ifdef CORELET_SEQ_ACC_EN
      begin
        int f = wi[wi.size() - 1] + 1;
        logic [9:0] ap = '0;
        for (int k = 0; k < KIJ; k++)
          chk("acc_rd", 35'({trace[f + k][32], trace[f + k][31], trace[f + k][30:20]}), 35'({2'b01, 11'(PB + k * NX)}));
        for (int k = 0; k <= KIJ; k++) ap[k] = trace[f + k][33];
        chk("acc_pattern", 35'(ap), 35'(10'b01_1111_1110));
        chk("bypass_low", 35'(hi[1]), 35'(0));
      end
`else
      chk("done_lag", 35'(trace.size() - 1 - wi[wi.size() - 1]), 35'(1));
      chk("bits_34_33", 35'(hi), 35'(0));
`endif
    end
  endtask

  initial begin
    repeat (3) @(negedge clk);
    cmp_on = 1;
    chk("rst_inst", inst, 35'h1_800C_0000);
    chk("rst_busy", 35'(busy), 35'(0));
    chk("rst_done", 35'(done), 35'(0));
    reset = 1;
    repeat (3) @(negedge clk);
    run_tile(1, 0);
    analyze(1);
    run_tile(0, 1);
    analyze(0);
    @(negedge clk); start = 1;
    @(negedge clk); start = 0;
    for (int i = 0; i < 500 && !inst[1]; i++) @(negedge clk);
    chk("reached_xfeed", 35'(inst[1]), 35'(1));
    @(posedge clk);
    #2 reset = 0;
    #1;
    chk("midrst_inst", inst, 35'h1_800C_0000);
    chk("midrst_busy", 35'(busy), 35'(0));
    repeat (2) @(negedge clk);
    reset = 1;
    repeat (20) @(negedge clk);
    run_tile(0, 1);
    analyze(0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/corelet_seq.md
CORELET_SEQ -- requirements
Module: corelet_seq

Interface
REQ-001 Parameter: row, 8, MAC array rows (weight vectors per kij).
REQ-002 Parameter: col, 8, MAC array columns.
REQ-003 Parameter: KIJ, 9, kernel positions per tile.
REQ-004 Parameter: N_X, 36, activation vectors per kij (equal to output vectors per kij).
REQ-005 Parameter: W_BASE / X_BASE / P_BASE, 0 / 128 / 0, 11-bit xmem weight, xmem activation and pmem base addresses.
REQ-006 Port: clk  input  1  clock.
REQ-007 Port: reset  input  1  reset; one clock, reset asynchronous and active-low.
REQ-008 Port: start  input  1  one-cycle request to run one tile.
REQ-009 Port: ofifo_valid  input  1  the OFIFO holds a readable psum vector.
REQ-010 Port: inst  output  35  registered corelet instruction word.
REQ-011 Port: busy  output  1  high from the cycle after an accepted start until done.
REQ-012 Port: done  output  1  one-cycle pulse at the end of a tile.

Function
REQ-013 inst fields SHALL be: [34] bypass, [33] acc, [32] CEN_pmem, [31] WEN_pmem, [30:20] A_pmem, [19] CEN_xmem, [18] WEN_xmem, [17:7] A_xmem, [6] ofifo_rd, [5] ififo_wr, [4] ififo_rd, [3] l0_rd, [2] l0_wr, [1] execute, [0] load; CEN and WEN are active-low.
REQ-014 The idle word SHALL be 35'h1_800C_0000 (CEN and WEN high, all other bits 0); inst SHALL carry the idle word in every cycle not defined below.
REQ-015 FSM states: IDLE, WLD, WLOAD, WGAP, XFEED, DRAIN, ACC, DONE; counter kij runs 0..KIJ-1.
REQ-016 IDLE->WLD on start with kij=0; start SHALL be ignored while busy.
REQ-017 WLD, row+1 cycles: in cycle c<row, xmem read (CEN=0, WEN=1) at A=W_BASE+kij*row+c; l0_wr=1 in cycles 1..row (1-cycle SRAM latency).
REQ-018 WLOAD, row cycles: l0_rd=1, load=1.
REQ-019 WGAP, row+col cycles: idle word.
REQ-020 XFEED, N_X+2 cycles: in cycle c<N_X, xmem read at X_BASE+c; l0_wr=1 in cycles 1..N_X; l0_rd=1 and execute=1 in cycles 2..N_X+1.
REQ-021 DRAIN: each cycle with ofifo_valid=1 SHALL assert ofifo_rd=1 plus a pmem write (CEN=0, WEN=0) at P_BASE+kij*N_X+n, then increment n; ofifo_valid=0 produces the idle word; exit when n reaches N_X.
REQ-022 After DRAIN: kij<KIJ-1 -> kij+1 and WLD; otherwise -> ACC (see REQ-027).
REQ-023 ACC: for each output o=0..N_X-1, KIJ+1 cycles; cycle k<KIJ issues a pmem read (CEN=0, WEN=1) at P_BASE+k*N_X+o; acc=1 in cycles 1..KIJ-1; acc=0 in cycle KIJ (ReLU and clear); bypass=0.
REQ-024 DONE: done=1 for one cycle, busy=0 in the same cycle, then IDLE.
REQ-025 Address arithmetic SHALL be 11-bit modulo 2^11 (wrap-around, no saturation).

Reset
REQ-026 While reset=0: inst=idle word, busy=0, done=0, state IDLE, all counters 0; reset mid-tile SHALL abort immediately, with no partial write completing after release.

Configuration
REQ-027 Macro CORELET_SEQ_ACC_EN: defined -> ACC state included per REQ-023; undefined -> the last DRAIN goes directly to DONE, and inst[33] and inst[34] are held at 0.

Structure
REQ-028 A shared package SHALL hold the inst bit-position constants, the idle word constant and the FSM state enum.
REQ-029 One sub-module, corelet_seq_addr, SHALL compute the xmem and pmem addresses from the state and counters.

Verification
REQ-030 Reset mid-XFEED -> inst=35'h1_800C_0000, busy=0 within the same cycle.
REQ-031 start with row=8 -> WLD reads A_xmem 0..7; l0_wr is high exactly 8 cycles, lagging the reads by 1 cycle.
REQ-032 ofifo_valid toggling 1,0,1,... in DRAIN (kij=2, N_X=36) -> 36 pmem writes at A_pmem 72..107, each with ofifo_rd=1; no write occurs when ofifo_valid=0.
REQ-033 CORELET_SEQ_ACC_EN defined -> output 0 reads A_pmem 0,36,...,288; acc pattern 0,1×8,0.
REQ-034 CORELET_SEQ_ACC_EN undefined -> done occurs 1 cycle after the 9th DRAIN; bits 34:33 are never set.
REQ-035 start pulsed while busy -> exactly one done pulse per tile.
